// File: rtl/ysyx_25040105_imem_responder.sv
// ysyx_25040105_imem_responder: fixed-latency instruction memory behind valid/ready fetch channels, one fetch outstanding.
module ysyx_25040105_imem_responder #(
   parameter logic [31:0] BASE    = 32'h8000_0000,
   parameter int          DEPTH   = 1024,
   parameter int          LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_inst,
   output logic        resp_err,
   input  logic        ld_en,
   input  logic [31:0] ld_addr,
   input  logic [31:0] ld_data
);
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
   localparam logic [3:0]  WAIT_CNT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t        r_state;
   logic [3:0]    r_cnt;
   logic [31:0]   r_inst;
   logic          r_err;
   logic [31:0]   r_mem [DEPTH];

   logic [31:0]   w_req_off;
   logic [31:0]   w_ld_off;
   logic [AW-1:0] w_req_idx;
   logic [AW-1:0] w_ld_idx;
   logic          w_req_err;
   logic          w_ld_ok;
   logic          w_accept;

   // Offsets wrap modulo 2^32, so addresses below BASE land far out of range.
   assign w_req_off = req_addr - BASE;
   assign w_ld_off  = ld_addr - BASE;
   assign w_req_err = (req_addr[1:0] != 2'b00) || (w_req_off >= SPAN);
   assign w_ld_ok   = (ld_addr[1:0] == 2'b00) && (w_ld_off < SPAN);
   assign w_req_idx = w_req_off[AW+1:2];
   assign w_ld_idx  = w_ld_off[AW+1:2];

   assign req_ready  = (r_state == S_IDLE) || ((r_state == S_RESP) && resp_ready);
   assign w_accept   = req_valid && req_ready;
   assign resp_valid = (r_state == S_RESP);
   assign resp_inst  = r_inst;
   assign resp_err   = r_err;

   always_ff @(posedge clk)
      if (ld_en && w_ld_ok) r_mem[w_ld_idx] <= ld_data;

   // The array is read on the accept edge, so a same-edge load returns the old word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_inst  <= '0;
         r_err   <= 1'b0;
      end else if (w_accept) begin
         r_state <= (LATENCY == 1) ? S_RESP : S_WAIT;
         r_cnt   <= WAIT_CNT;
         r_inst  <= w_req_err ? '0 : r_mem[w_req_idx];
         r_err   <= w_req_err;
      end else if (r_state == S_WAIT) begin
         if (r_cnt == '0) r_state <= S_RESP;
         else r_cnt <= r_cnt - 4'd1;
      end else if ((r_state == S_RESP) && resp_ready) begin
         r_state <= S_IDLE;
      end
   end
endmodule

// File: tb/tb_ysyx_25040105_imem_responder.sv
// tb_ysyx_25040105_imem_responder: scoreboard bench over three responders (latency 2, 1, 7); instance 0 also runs directed cases.
module tb_ysyx_25040105_imem_responder;
   localparam logic [31:0] BASE  = 32'h8000_0000;
   localparam int          DEPTH = 1024;

   typedef struct {logic err; logic [31:0] inst; int c;} exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [2:0]  resp_valid;
   logic [2:0]  resp_ready;
   logic [2:0]  resp_err;
   logic [2:0]  ld_en;
   logic [31:0] req_addr [3];
   logic [31:0] resp_inst [3];
   logic [31:0] ld_addr [3];
   logic [31:0] ld_data [3];
   int          nchk = 0;
   int          nerr = 0;
   int          nacc [3] = '{0, 0, 0};
   int          pend [3] = '{0, 0, 0};

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit in_map(input logic [31:0] a);
      return (a % 4 == 0) && longint'(a) >= longint'(BASE) && longint'(a) < longint'(BASE) + DEPTH * 4;
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((longint'(a) - longint'(BASE)) / 4);
   endfunction

   for (genvar g = 0; g < 3; g++) begin : g_i
      localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 7;
      exp_t        q [$];
      logic [31:0] mem [int];
      int          cyc = 0;
      bit          ev;
      bit          er;

      ysyx_25040105_imem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(L)) u_dut (
         .clk(clk), .rst(rst),
         .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_addr(req_addr[g]),
         .resp_valid(resp_valid[g]), .resp_ready(resp_ready[g]),
         .resp_inst(resp_inst[g]), .resp_err(resp_err[g]),
         .ld_en(ld_en[g]), .ld_addr(ld_addr[g]), .ld_data(ld_data[g]));

      always @(negedge rst) begin
         q.delete();
         pend[g] = 0;
      end

      // Expected response is due L samples after the accepting sample and stays until handshaken.
      always @(negedge clk) begin
         #4;
         if (rst) begin
            ev = 1'b0;
            if (q.size() > 0) ev = (cyc >= q[0].c + L);
            er = (q.size() == 0) || (ev && resp_ready[g]);
            chk($sformatf("resp_valid[%0d]", g), 32'(resp_valid[g]), 32'(ev));
            chk($sformatf("req_ready[%0d]", g), 32'(req_ready[g]), 32'(er));
            if (ev) begin
               chk($sformatf("resp_inst[%0d]", g), resp_inst[g], q[0].inst);
               chk($sformatf("resp_err[%0d]", g), 32'(resp_err[g]), 32'(q[0].err));
               if (resp_ready[g]) void'(q.pop_front());
            end
            if (req_valid[g] && er) begin
               if (in_map(req_addr[g])) q.push_back('{1'b0, mem[widx(req_addr[g])], cyc});
               else q.push_back('{1'b1, 32'h0, cyc});
               nacc[g]++;
            end
            if (ld_en[g] && in_map(ld_addr[g])) mem[widx(ld_addr[g])] = ld_data[g];
            pend[g] = q.size();
            cyc++;
         end
      end
   end

   task automatic req0(input logic [31:0] a);
      bit ok = 1'b0;
      req_valid[0] = 1'b1;
      req_addr[0]  = a;
      for (int i = 0; i < 40 && !ok; i++) begin
         #1 ok = req_ready[0];
         if (!ok) @(negedge clk);
      end
      chk("req0_accept", 32'(ok), 32'd1);
      @(negedge clk);
      req_valid[0] = 1'b0;
   endtask

   task automatic idle0();
      for (int i = 0; i < 40 && pend[0] != 0; i++) @(negedge clk);
      chk("idle0_drain", pend[0], 32'd0);
   endtask

   initial begin
      logic [31:0] d;
      int          b [3];
      int          r;
      req_valid  = '0;
      resp_ready = '0;
      ld_en      = '0;
      for (int k = 0; k < 3; k++) begin
         req_addr[k] = BASE;
         ld_addr[k]  = BASE;
         ld_data[k]  = '0;
      end
      repeat (3) @(negedge clk);
      #2;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rst_resp_valid[%0d]", k), 32'(resp_valid[k]), 32'd0);
         chk($sformatf("rst_resp_inst[%0d]", k), resp_inst[k], 32'd0);
         chk($sformatf("rst_resp_err[%0d]", k), 32'(resp_err[k]), 32'd0);
         chk($sformatf("rst_req_ready[%0d]", k), 32'(req_ready[k]), 32'd1);
      end
      @(negedge clk) rst = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         d = (i == 0) ? 32'h0000_0413 : (i == 3) ? 32'h0000_0013 : $urandom;
         for (int k = 0; k < 3; k++) begin
            ld_en[k]   = 1'b1;
            ld_addr[k] = 32'(BASE + 4 * i);
            ld_data[k] = d;
         end
         @(negedge clk);
      end
      ld_en = '0;
      resp_ready[0] = 1'b1;
      req0(BASE);
      idle0();
      req0(BASE + 32'h2);
      idle0();
      req0(BASE + 32'h1000);
      idle0();
      // Stall a response for five cycles, then handshake it together with the next accept.
      resp_ready[0] = 1'b0;
      req0(BASE);
      repeat (6) @(negedge clk);
      resp_ready[0] = 1'b1;
      req0(BASE + 32'h4);
      idle0();
      req_valid[0] = 1'b1;
      req_addr[0]  = BASE + 32'hC;
      ld_en[0]     = 1'b1;
      ld_addr[0]   = BASE + 32'hC;
      ld_data[0]   = 32'hDEAD_BEEF;
      #1 chk("ld_edge_req_ready", 32'(req_ready[0]), 32'd1);
      @(negedge clk);
      req_valid[0] = 1'b0;
      ld_en[0]     = 1'b0;
      idle0();
      req0(BASE + 32'hC);
      idle0();
      req0(BASE + 32'h10);
      #2 rst = 1'b0;
      #1 chk("wait_rst_resp_valid", 32'(resp_valid[0]), 32'd0);
      chk("wait_rst_req_ready", 32'(req_ready[0]), 32'd1);
      @(negedge clk) rst = 1'b1;
      repeat (10) @(negedge clk);
      resp_ready[0] = 1'b0;
      req0(BASE + 32'h14);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 chk("resp_rst_resp_valid", 32'(resp_valid[0]), 32'd0);
      chk("resp_rst_resp_inst", resp_inst[0], 32'd0);
      @(negedge clk) rst = 1'b1;
      repeat (10) @(negedge clk);
      for (int k = 0; k < 3; k++) b[k] = nacc[k];
      for (int t = 0; t < 8000 && (nacc[0] < b[0] + 100 || nacc[1] < b[1] + 100 || nacc[2] < b[2] + 100); t++) begin
         for (int k = 0; k < 3; k++) begin
            r = int'($urandom_range(0, 15));
            req_valid[k]  = ($urandom_range(0, 3) != 0);
            req_addr[k]   = (r == 0) ? 32'(BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3)) :
                            (r == 1) ? 32'(BASE + DEPTH * 4 + 4 * $urandom_range(0, 63)) :
                                       32'(BASE + 4 * $urandom_range(0, DEPTH - 1));
            resp_ready[k] = ($urandom_range(0, 2) != 0);
            ld_en[k]      = ($urandom_range(0, 5) == 0);
            ld_addr[k]    = (r == 2) ? 32'(BASE - 4 * $urandom_range(1, 8)) :
                                       32'(BASE + 4 * $urandom_range(0, DEPTH - 1) + ((r == 3) ? 1 : 0));
            ld_data[k]    = $urandom;
         end
         @(negedge clk);
      end
      req_valid  = '0;
      ld_en      = '0;
      resp_ready = '1;
      repeat (20) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("stream_accepts[%0d]", k), 32'(nacc[k] - b[k] >= 100), 32'd1);
         chk($sformatf("stream_drained[%0d]", k), pend[k], 32'd0);
      end
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end
endmodule
